// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result bundle between a requester and the serial BCD add controller.
// The requester drives the operands and start; the controller returns status and result.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  Cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a, b, Cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, Cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder sequencer around one shared single-digit BCD adder.
// Feeds one digit pair per cycle, LSD first, rippling the decimal carry in a register.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_serial_add_ctrl_if.slave req,
  output logic [3:0]           dig_a,
  output logic [3:0]           dig_b,
  output logic                 dig_cin,
  input  logic [3:0]           dig_sum,
  input  logic                 dig_cout
);

  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  typedef logic [DIGITS-1:0][3:0] bcd_t;

  state_t        state_q;
  state_t        state_d;
  bcd_t          a_in;
  bcd_t          b_in;
  bcd_t          a_q;
  bcd_t          b_q;
  bcd_t          sum_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic          cout_q;
  logic          err_q;
  logic          accept;
  logic          bad;
  logic          adding;
  logic          last;

  assign a_in   = req.a;
  assign b_in   = req.b;
  assign adding = state_q == S_ADD;
  assign accept = req.start && !adding;
  assign last   = idx_q == IW'(DIGITS - 1);

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_in[i] > 4'd9 || b_in[i] > 4'd9) begin
        bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req.busy = 1'b0;
    req.done = 1'b0;
    dig_a    = '0;
    dig_b    = '0;
    dig_cin  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = bad ? S_DONE : S_ADD;
        end
      end
      S_ADD: begin
        req.busy = 1'b1;
        dig_a    = a_q[idx_q];
        dig_b    = b_q[idx_q];
        dig_cin  = carry_q;
        if (last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        req.done = 1'b1;
        if (accept) begin
          state_d = bad ? S_DONE : S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // idx holds on the last digit so it never wraps mid-operation
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          a_q     <= a_in;
          b_q     <= b_in;
          sum_q   <= '0;
          idx_q   <= '0;
          carry_q <= req.Cin;
          cout_q  <= 1'b0;
          err_q   <= bad;
        end
        adding: begin
          sum_q[idx_q] <= dig_sum;
          carry_q      <= dig_cout;
          if (last) begin
            cout_q <= dig_cout;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req.sum  = sum_q;
  assign req.cout = cout_q;
  assign req.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl with a behavioural digit adder.
// Expected values come from decimal arithmetic on the operands.
module tb_bcd_serial_add_ctrl;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dig_a;
  logic [3:0] dig_b;
  logic       dig_cin;
  logic [3:0] dig_sum;
  logic       dig_cout;
  logic [4:0] s5;
  int         checks = 0;
  int         fails = 0;

  bcd_serial_add_ctrl_if #(.DIGITS(D)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .dig_a   (dig_a),
    .dig_b   (dig_b),
    .dig_cin (dig_cin),
    .dig_sum (dig_sum),
    .dig_cout(dig_cout)
  );

  always #5 clk = ~clk;

  always_comb begin
    s5 = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, dig_cin};
    if (s5 > 5'd9) begin
      dig_sum  = 4'(s5 - 5'd10);
      dig_cout = 1'b1;
    end else begin
      dig_sum  = s5[3:0];
      dig_cout = 1'b0;
    end
  end

  function automatic int bcd2int(logic [15:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i+:4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(int n);
    logic [15:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i+:4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic carry_in(logic [15:0] a, logic [15:0] b,
                                    logic c, int i);
    int p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    return (bcd2int(a) % p + bcd2int(b) % p + int'(c)) >= p;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < D; i++) r[4*i+:4] = 4'($urandom_range(9));
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.Cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.cout, bus.err} !== 4'b0)
      $display("FAIL reset_flags: busy/done/cout/err=%b required 0000",
               {bus.busy, bus.done, bus.cout, bus.err});
    checks++;
    if (bus.sum !== 16'h0)
      $display("FAIL reset_sum: got %h required 0000", bus.sum);
    checks++;
    if ({dig_a, dig_b, dig_cin} !== 9'b0)
      $display("FAIL reset_dig: a=%h b=%h cin=%b required 0", dig_a, dig_b, dig_cin);
    fails += ({bus.busy, bus.done, bus.cout, bus.err} !== 4'b0) +
             (bus.sum !== 16'h0) + ({dig_a, dig_b, dig_cin} !== 9'b0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic        tc [3];
    logic [15:0] ts [3];
    logic        to [3];
    logic [15:0] va;
    logic [15:0] vb;
    ta = '{16'h1234, 16'h9999, 16'h0000};
    tb = '{16'h5678, 16'h0001, 16'h0000};
    tc = '{1'b0, 1'b0, 1'b1};
    ts = '{16'h6912, 16'h0000, 16'h0001};
    to = '{1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 3; t++) begin
      va = ta[t];
      vb = tb[t];
      bus.a = va;
      bus.b = vb;
      bus.Cin = tc[t];
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < D; i++) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          fails++;
          $display("FAIL dir%0d_busy c%0d: busy=%b done=%b required 1 0",
                   t, i, bus.busy, bus.done);
        end
        checks++;
        if ({dig_a, dig_b, dig_cin} !==
            {va[4*i+:4], vb[4*i+:4], carry_in(va, vb, tc[t], i)}) begin
          fails++;
          $display("FAIL dir%0d_dig c%0d: got %h+%h+%b required %h+%h+%b",
                   t, i, dig_a, dig_b, dig_cin, va[4*i+:4], vb[4*i+:4],
                   carry_in(va, vb, tc[t], i));
        end
        @(negedge clk);
      end
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL dir%0d_done: done=%b busy=%b required 1 0",
                 t, bus.done, bus.busy);
      end
      checks++;
      if (bus.sum !== ts[t] || bus.cout !== to[t] || bus.err !== 1'b0) begin
        fails++;
        $display("FAIL dir%0d_result: sum=%h cout=%b err=%b required %h %b 0",
                 t, bus.sum, bus.cout, bus.err, ts[t], to[t]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_error();
    bus.a = 16'h12A4;
    bus.b = 16'h0000;
    bus.Cin = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.err, bus.busy, bus.cout} !== 4'b1100 ||
        bus.sum !== 16'h0 || {dig_a, dig_b} !== 8'h0) begin
      fails++;
      $display("FAIL err_a: done/err/busy/cout=%b sum=%h dig=%h%h required 1100 0000 00",
               {bus.done, bus.err, bus.busy, bus.cout}, bus.sum, dig_a, dig_b);
    end
    bus.b = 16'h00F0;
    bus.a = 16'h0000;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.err, bus.busy} !== 3'b110) begin
      fails++;
      $display("FAIL err_b_restart: done/err/busy=%b required 110",
               {bus.done, bus.err, bus.busy});
    end
    bus.a = 16'h0123;
    bus.b = 16'h0456;
    bus.Cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: busy=%b err=%b required 1 0", bus.busy, bus.err);
    end
    repeat (D) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.sum !== 16'h0579 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL err_recover: done=%b sum=%h err=%b required 1 0579 0",
               bus.done, bus.sum, bus.err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    bus.a = 16'h0000;
    bus.b = 16'h0000;
    bus.Cin = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (D) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.sum !== 16'h0001 || bus.cout !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: done=%b sum=%h cout=%b required 1 0001 0",
               bus.done, bus.sum, bus.cout);
    end
    bus.a = 16'h4999;
    bus.b = 16'h5000;
    bus.Cin = 1'b1;
    bus.start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end while (bus.done !== 1'b1 && n < 12);
    checks++;
    if (n != D + 1) begin
      fails++;
      $display("FAIL b2b_latency: got %0d cycles required %0d", n, D + 1);
    end
    checks++;
    if (bus.sum !== 16'h0000 || bus.cout !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second: sum=%h cout=%b required 0000 1", bus.sum, bus.cout);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int dcount = 0;
    bus.a = 16'h2468;
    bus.b = 16'h1357;
    bus.Cin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a = 16'h9999;
    bus.b = 16'h9999;
    bus.Cin = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (i == D - 1) bus.start = 1'b0;
      dcount += int'(bus.done);
      @(negedge clk);
    end
    checks++;
    if (dcount != 0 || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL ign_done: early=%0d done=%b required 0 1", dcount, bus.done);
    end
    checks++;
    if (bus.sum !== 16'h3825 || bus.cout !== 1'b0) begin
      fails++;
      $display("FAIL ign_result: sum=%h cout=%b required 3825 0", bus.sum, bus.cout);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL ign_idle: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_rst_mid();
    int dcount = 0;
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.Cin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.cout, bus.err} !== 4'b0 || bus.sum !== 16'h0 ||
        {dig_a, dig_b, dig_cin} !== 9'b0) begin
      fails++;
      $display("FAIL rst_mid: flags=%b sum=%h dig=%h%h%b required all 0",
               {bus.busy, bus.done, bus.cout, bus.err}, bus.sum, dig_a, dig_b, dig_cin);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_wins: busy=%b required 0", bus.busy);
    end
    for (int i = 0; i < 6; i++) begin
      dcount += int'(bus.done);
      @(negedge clk);
    end
    checks++;
    if (dcount != 0) begin
      fails++;
      $display("FAIL rst_nodone: got %0d done pulses required 0", dcount);
    end
    bus.a = 16'h0505;
    bus.b = 16'h0505;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (D) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.sum !== 16'h1010 || bus.cout !== 1'b0) begin
      fails++;
      $display("FAIL rst_fresh: done=%b sum=%h cout=%b required 1 1010 0",
               bus.done, bus.sum, bus.cout);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] esum;
    logic        vc;
    logic        bad;
    logic        ecout;
    int          total;
    int          pos;
    for (int n = 0; n < 60; n++) begin
      va = rand_bcd();
      vb = rand_bcd();
      vc = 1'($urandom_range(1));
      bad = $urandom_range(7) == 0;
      if (bad) begin
        pos = $urandom_range(D - 1);
        if ($urandom_range(1) == 1) va[4*pos+:4] = 4'($urandom_range(15, 10));
        else vb[4*pos+:4] = 4'($urandom_range(15, 10));
      end
      total = bcd2int(va) + bcd2int(vb) + int'(vc);
      ecout = total >= 10000;
      esum = int2bcd(total % 10000);
      bus.a = va;
      bus.b = vb;
      bus.Cin = vc;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      if (bad) begin
        checks++;
        if ({bus.done, bus.err, bus.busy, bus.cout} !== 4'b1100 || bus.sum !== 16'h0) begin
          fails++;
          $display("FAIL rnd%0d_err: a=%h b=%h flags=%b sum=%h required 1100 0000",
                   n, va, vb, {bus.done, bus.err, bus.busy, bus.cout}, bus.sum);
        end
      end else begin
        for (int i = 0; i < D; i++) begin
          checks++;
          if (bus.busy !== 1'b1 || {dig_a, dig_b, dig_cin} !==
              {va[4*i+:4], vb[4*i+:4], carry_in(va, vb, vc, i)}) begin
            fails++;
            $display("FAIL rnd%0d_dig c%0d: busy=%b got %h+%h+%b required %h+%h+%b",
                     n, i, bus.busy, dig_a, dig_b, dig_cin, va[4*i+:4], vb[4*i+:4],
                     carry_in(va, vb, vc, i));
          end
          @(negedge clk);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0 ||
            bus.sum !== esum || bus.cout !== ecout) begin
          fails++;
          $display("FAIL rnd%0d_result: %h+%h+%b done=%b sum=%h cout=%b err=%b required 1 %h %b 0",
                   n, va, vb, vc, bus.done, bus.sum, bus.cout, bus.err, esum, ecout);
        end
      end
      if ($urandom_range(1) == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_error();
    test_back_to_back();
    test_ignore_start();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Sequencing controller that performs a multi-digit packed-BCD addition by time-multiplexing one external combinational single-digit BCD adder. It accepts two DIGITS-wide BCD operands on a start pulse and feeds the shared adder one digit pair per cycle, least significant first. It ripples the decimal carry through a register, assembles the result and signals completion. It sits between the operand source (register file or test sequencer) and the single-digit BCD adder datapath.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥2)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE or DONE
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
- b  in  4*DIGITS  operand B, packed BCD
- Cin  in  1  initial decimal carry-in
- dig_a  out  4  digit of A presented to the shared adder
- dig_b  out  4  digit of B presented to the shared adder
- dig_cin  out  1  carry presented to the shared adder
- dig_sum  in  4  BCD sum digit returned by the adder (combinational)
- dig_cout  in  1  decimal carry returned by the adder
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle completion strobe
- sum  out  4*DIGITS  packed BCD result, held until the next accepted start
- cout  out  1  final decimal carry
- err  out  1  operand contained a non-BCD digit (>9)

## Operation
- States: IDLE, ADD, DONE.
- IDLE: dig_a, dig_b and dig_cin are driven to 0. On start=1, the block registers a, b and Cin, clears sum, cout and err, sets carry to Cin and idx to 0.
  - If any digit of a or b is >9: err←1 and the next state is DONE. The adder is never driven.
  - Otherwise the next state is ADD.
- ADD: dig_a = A_reg[4*idx+:4], dig_b = B_reg[4*idx+:4], dig_cin = carry. These are combinational from the registers.
  - At each edge: sum[4*idx+:4]←dig_sum, carry←dig_cout, idx←idx+1.
  - When idx = DIGITS-1: cout←dig_cout and the next state is DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or a new operation if start=1 in this cycle. A restart follows the same accept rules as in IDLE.
- start while in ADD is ignored. No queuing.
- idx width is $clog2(DIGITS). idx never wraps inside an operation. It resets to 0 on every accept.
- The shared adder is trusted to return valid BCD. dig_sum is not rechecked.
- err and sum are mutually exclusive: sum=0 and cout=0 whenever err=1.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, dig_a=0, dig_b=0, dig_cin=0, idx=0, carry=0.
- Start accepted at edge k. busy=1 in cycles k+1 … k+DIGITS. The last digit is captured at edge k+DIGITS. done=1 in cycle k+DIGITS+1, during which busy=0.
- Latency from start to done is DIGITS+1 cycles. Throughput is one operation per DIGITS+1 cycles with back-to-back starts in DONE.
- Error path: start at edge k gives done=1, err=1 in cycle k+1. busy stays 0.
- sum, cout and err are stable from the done cycle until the edge that accepts the next start.
- rst=1 in any state, including mid-ADD: at the next edge all registers return to their reset values. A partial result is discarded and no done is issued.
- start and rst high together: rst wins.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, Cin=0, single start -> digits presented 4+8, 3+7, 2+6, 1+5 in successive cycles; done at start+5; sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, Cin=0 -> carry ripples through all digits; sum=0x0000, cout=1; dig_cin reads 0,1,1,1 across ADD cycles.
- a=0x0000, b=0x0000, Cin=1 -> sum=0x0001, cout=0. Then a back-to-back start in the DONE cycle with a=0x4999, b=0x5000, Cin=1 -> sum=0x0000, cout=1 exactly 5 cycles later.
- a=0x12A4 (invalid digit) -> done and err=1 one cycle after start; sum=0, cout=0, busy never asserted; dig_a/dig_b remain 0.
- Extra start pulses during ADD with different operands -> ignored; result equals the first operation.
- rst asserted at the third ADD cycle -> next cycle all outputs are 0 and state is IDLE, with no done; a fresh start afterward completes correctly.
